// File: rtl/byte_striping_param.sv
// Transmit-side byte striper: collects DATA_W-bit words round-robin into LANES slots
// and presents each completed (or flushed, IDLE-padded) group on all lanes at once.
module byte_striping_param #(
   parameter int                LANES     = 4,
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] IDLE_CODE = 8'h00
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enb,
   input  logic [DATA_W-1:0]          tx_DataE,
   input  logic                       tx_ValidE,
   input  logic                       flush,
   output logic [LANES*DATA_W-1:0]    tx_lanes,
   output logic [LANES-1:0]           tx_lane_valid,
   output logic                       tx_group,
   output logic [$clog2(LANES)-1:0]   fill_level
);

   localparam int CW = $clog2(LANES);

   logic [CW-1:0]             cnt;
   logic [DATA_W-1:0]         slots [LANES];
   logic                      accept;
   logic                      full;
   logic                      emit;
   logic [CW:0]               pending;
   logic [LANES*DATA_W-1:0]   next_lanes;
   logic [LANES-1:0]          next_valid;

   // Pending count includes a word accepted on this same edge, so a flush
   // alongside a data word closes the group with that word in it.
   always_comb begin
      accept     = enb & tx_ValidE;
      pending    = {1'b0, cnt} + (CW+1)'(accept);
      full       = accept && (cnt == CW'(LANES-1));
      emit       = enb && (full || (flush && (pending != '0)));
      next_lanes = {LANES{IDLE_CODE}};
      next_valid = '0;
      for (int k = 0; k < LANES; k++) begin
         if ((CW+1)'(k) < {1'b0, cnt}) begin
            next_lanes[k*DATA_W +: DATA_W] = slots[k];
         end else if (accept && ((CW+1)'(k) == {1'b0, cnt})) begin
            next_lanes[k*DATA_W +: DATA_W] = tx_DataE;
         end
         next_valid[k] = ((CW+1)'(k) < pending);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt           <= '0;
         tx_lanes      <= {LANES{IDLE_CODE}};
         tx_lane_valid <= '0;
         tx_group      <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            slots[k] <= IDLE_CODE;
         end
      end else begin
         tx_group <= 1'b0;
         if (emit) begin
            tx_lanes      <= next_lanes;
            tx_lane_valid <= next_valid;
            tx_group      <= 1'b1;
            cnt           <= '0;
         end else if (accept) begin
            slots[cnt] <= tx_DataE;
            cnt        <= cnt + CW'(1);
         end
      end
   end

   assign fill_level = cnt;

endmodule
